// File: rtl/mips_mem_pkg.sv
// Shared types and timeout sizing for the simpleMIPS unified-memory arbiter, memory model and bench.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    localparam int unsigned TMO_CYCLES_DEF = 255;

    // Timer width able to hold TMO_CYCLES; at least one bit so a disabled timer still has a legal width.
    function automatic int unsigned tmo_width(input int unsigned cycles);
        return (cycles == 0) ? 1 : $clog2(cycles + 1);
    endfunction

    localparam int unsigned TMO_W = tmo_width(TMO_CYCLES_DEF);

endpackage

// File: rtl/mem_arb_timer.sv
// BUSY-phase watchdog: cleared while idle, counts while enabled, flags expiry on the last allowed cycle.
module mem_arb_timer #(
    parameter int unsigned TMO_CYCLES = 255,
    parameter int unsigned W          = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire_c
);

    generate
        if (TMO_CYCLES == 0) begin : g_off
            logic unused_tmr;
            assign unused_tmr = &{1'b0, clk, rst, clr, en};
            assign expire_c   = 1'b0;
        end else begin : g_on
            logic [W-1:0] cnt;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt <= '0;
                end else if (clr) begin
                    cnt <= '0;
                end else if (en) begin
                    cnt <= cnt + W'(1);
                end
            end

            assign expire_c = en && (cnt == W'(TMO_CYCLES - 1));
        end
    endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch (I) and load/store (D) ports onto one variable-latency single-port memory.
// Define ARB_ROUND_ROBIN_EN for alternating grants on contention; default is fixed D-over-I priority.
module mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned TMO_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_ack,
    output logic [DW-1:0]   i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_ack,
    output logic [DW-1:0]   d_rdata,
    output logic            m_req,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_be,
    input  logic            m_ack,
    input  logic [DW-1:0]   m_rdata,
    output logic            bus_err
);

    localparam int unsigned TW = tmo_width(TMO_CYCLES);

    arb_state_t state;
    arb_state_t state_nxt;
    owner_t     owner;
    owner_t     grant_c;
    logic       any_req_c;
    logic       done_c;
    logic       expire_c;

    assign any_req_c = i_req | d_req;
    assign done_c    = m_ack | expire_c;

`ifdef ARB_ROUND_ROBIN_EN
    owner_t last_owner;

    // On contention hand the grant to whichever port did not win last time.
    always_comb begin
        grant_c = OWN_D;
        if (i_req && d_req) begin
            grant_c = (last_owner == OWN_D) ? OWN_I : OWN_D;
        end else if (i_req) begin
            grant_c = OWN_I;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner <= OWN_I;
        end else if (state == ARB_IDLE && any_req_c) begin
            last_owner <= grant_c;
        end
    end
`else
    always_comb begin
        grant_c = d_req ? OWN_D : OWN_I;
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: if (any_req_c) state_nxt = ARB_BUSY;
            ARB_BUSY: if (done_c)    state_nxt = ARB_RESP;
            ARB_RESP:                state_nxt = ARB_IDLE;
            default:                 state_nxt = ARB_IDLE;
        endcase
    end

    mem_arb_timer #(
        .TMO_CYCLES (TMO_CYCLES),
        .W          (TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (state == ARB_IDLE),
        .en       (state == ARB_BUSY),
        .expire_c (expire_c)
    );

    // Memory-side fields are latched at grant so requester changes during BUSY cannot leak through.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ARB_IDLE;
            owner   <= OWN_I;
            i_ack   <= 1'b0;
            i_rdata <= '0;
            d_ack   <= 1'b0;
            d_rdata <= '0;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_be    <= '0;
            bus_err <= 1'b0;
        end else begin
            state <= state_nxt;
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (any_req_c) begin
                        owner <= grant_c;
                        m_req <= 1'b1;
                        if (grant_c == OWN_D) begin
                            m_we    <= d_we;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                            m_be    <= d_be;
                        end else begin
                            m_we    <= 1'b0;
                            m_addr  <= i_addr;
                            m_wdata <= '0;
                            m_be    <= '0;
                        end
                    end
                end
                ARB_BUSY: begin
                    if (done_c) begin
                        m_req <= 1'b0;
                        if (owner == OWN_D) begin
                            d_ack   <= 1'b1;
                            d_rdata <= m_ack ? m_rdata : '0;
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= m_ack ? m_rdata : '0;
                        end
                        if (!m_ack) begin
                            bus_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
